// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes,
// funct codes and the datapath select/operation encodings.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IF     = 4'd0,
      S_ID     = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_WBLW   = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXR    = 4'd6,
      S_WBR    = 4'd7,
      S_EXBR   = 4'd8,
      S_EXJ    = 4'd9,
      S_EXI    = 4'd10,
      S_WBI    = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_NOR = 3'b100;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] D2R_ALU = 2'b00;
   localparam logic [1:0] D2R_MDR = 2'b01;
   localparam logic [1:0] D2R_PC  = 2'b10;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BEQ  = 2'b01;
   localparam logic [1:0] BR_BNE  = 2'b10;
   localparam logic [1:0] BR_JUMP = 2'b11;

   // Only the signed-arithmetic instructions trap on overflow.
   function automatic logic is_trap_op(input logic [5:0] opcode, input logic [5:0] funct);
      return (opcode == OP_ADDI) ||
             ((opcode == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB)));
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational opcode/funct decode to ALU operation; o_valid is low for any
// encoding the control unit does not implement.
module alu_decoder
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output logic [2:0] o_alu_ctrl,
   output logic       o_valid
);

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      o_alu_ctrl = ALU_ADD;
      o_valid    = 1'b1;
      unique case (i_opcode)
         OP_RTYPE: begin
            unique case (i_funct)
               FN_ADD:  o_alu_ctrl = ALU_ADD;
               FN_SUB:  o_alu_ctrl = ALU_SUB;
               FN_AND:  o_alu_ctrl = ALU_AND;
               FN_OR:   o_alu_ctrl = ALU_OR;
               FN_SLT:  o_alu_ctrl = ALU_SLT;
               FN_NOR:  o_alu_ctrl = ALU_NOR;
               default: o_valid    = 1'b0;
            endcase
         end
         OP_LW, OP_SW, OP_ADDI, OP_J, OP_JAL: o_alu_ctrl = ALU_ADD;
         OP_BEQ, OP_BNE: o_alu_ctrl = ALU_SUB;
         OP_ANDI:        o_alu_ctrl = ALU_AND;
         OP_ORI:         o_alu_ctrl = ALU_OR;
         OP_SLTI:        o_alu_ctrl = ALU_SLT;
         default:        o_valid    = 1'b0;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and stalls in memory states until the unified memory reports ready.
module multi_cycle_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       overflow,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RedDst,
   output logic       ALUSrc_A,
   output logic [1:0] ALUSrc_B,
   output logic [2:0] ALU_Control,
   output logic [1:0] DatatoReg,
   output logic       RegWrite,
   output logic [1:0] Branch,
   output logic       Jal,
   output logic       illegal,
   output logic       ovf_exc,
   output logic [3:0] state
);

   state_t     r_state;
   state_t     w_next;
   logic       r_ovf_q;
   logic [2:0] w_dec_alu;
   logic       w_dec_valid;
   logic       w_unused_zero;

   // Branch qualification with the zero flag happens in the datapath.
   assign w_unused_zero = zero;

   alu_decoder u_alu_decoder (
      .i_opcode   (opcode),
      .i_funct    (funct),
      .o_alu_ctrl (w_dec_alu),
      .o_valid    (w_dec_valid)
   );

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IF;
         r_ovf_q <= 1'b0;
      end else begin
         r_state <= w_next;
         unique case (r_state)
            S_EXR, S_EXI: r_ovf_q <= overflow & is_trap_op(opcode, funct);
            S_WBR, S_WBI: r_ovf_q <= 1'b0;
            default:      r_ovf_q <= r_ovf_q;
         endcase
      end
   end

   always_comb begin
      w_next      = r_state;
      PCWrite     = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RedDst      = 1'b0;
      ALUSrc_A    = 1'b0;
      ALUSrc_B    = SRCB_FOUR;
      ALU_Control = ALU_ADD;
      DatatoReg   = D2R_ALU;
      RegWrite    = 1'b0;
      Branch      = BR_NONE;
      Jal         = 1'b0;
      illegal     = 1'b0;
      ovf_exc     = 1'b0;

      unique case (r_state)
         S_IF: begin
            MemRead = 1'b1;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready) w_next = S_ID;
         end
         S_ID: begin
            ALUSrc_B = SRCB_IMM_SH;
            illegal  = ~w_dec_valid;
            w_next   = S_IF;
            if (w_dec_valid) begin
               unique case (opcode)
                  OP_RTYPE:                           w_next = S_EXR;
                  OP_LW, OP_SW:                       w_next = S_MEMADR;
                  OP_BEQ, OP_BNE:                     w_next = S_EXBR;
                  OP_J, OP_JAL:                       w_next = S_EXJ;
                  OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  w_next = S_EXI;
                  default:                            w_next = S_IF;
               endcase
            end
         end
         S_MEMADR: begin
            ALUSrc_A    = 1'b1;
            ALUSrc_B    = SRCB_IMM;
            ALU_Control = w_dec_alu;
            w_next      = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
            if (mem_ready) w_next = S_WBLW;
         end
         S_WBLW: begin
            DatatoReg = D2R_MDR;
            RegWrite  = 1'b1;
            w_next    = S_IF;
         end
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) w_next = S_IF;
         end
         S_EXR: begin
            ALUSrc_A    = 1'b1;
            ALUSrc_B    = SRCB_RT;
            ALU_Control = w_dec_alu;
            w_next      = S_WBR;
         end
         S_WBR: begin
            RedDst   = 1'b1;
            RegWrite = ~r_ovf_q;
            ovf_exc  = r_ovf_q;
            w_next   = S_IF;
         end
         S_EXBR: begin
            ALUSrc_A    = 1'b1;
            ALUSrc_B    = SRCB_RT;
            ALU_Control = ALU_SUB;
            Branch      = (opcode == OP_BNE) ? BR_BNE : BR_BEQ;
            w_next      = S_IF;
         end
         S_EXJ: begin
            Branch = BR_JUMP;
            if (opcode == OP_JAL) begin
               Jal       = 1'b1;
               DatatoReg = D2R_PC;
               RegWrite  = 1'b1;
            end
            w_next = S_IF;
         end
         S_EXI: begin
            ALUSrc_A    = 1'b1;
            ALUSrc_B    = SRCB_IMM;
            ALU_Control = w_dec_alu;
            w_next      = S_WBI;
         end
         S_WBI: begin
            RegWrite = ~r_ovf_q;
            ovf_exc  = r_ovf_q;
            w_next   = S_IF;
         end
         default: w_next = S_IF;
      endcase
   end

   assign state = r_state;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: expectations are queued per cycle and
// popped/compared against the DUT outputs in that same cycle.
module tb_multi_cycle_ctrl;

   typedef enum int {
      F_STATE, F_PCW, F_IORD, F_MRD, F_MWR, F_IRW, F_REGDST, F_SRCA,
      F_SRCB, F_ALU, F_D2R, F_RW, F_BR, F_JAL, F_ILL, F_OVF
   } field_e;

   typedef struct {
      field_e     f;
      logic [3:0] v;
      string      tag;
   } sb_t;

   logic       clk;
   logic       rst;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       overflow;
   logic       mem_ready;
   logic       PCWrite, IorD, MemRead, MemWrite, IRWrite, RedDst, ALUSrc_A;
   logic [1:0] ALUSrc_B;
   logic [2:0] ALU_Control;
   logic [1:0] DatatoReg;
   logic       RegWrite;
   logic [1:0] Branch;
   logic       Jal, illegal, ovf_exc;
   logic [3:0] state;

   sb_t sb[$];
   int  n_pass  = 0;
   int  n_total = 0;

   multi_cycle_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct      (funct),
      .zero       (zero),
      .overflow   (overflow),
      .mem_ready  (mem_ready),
      .PCWrite    (PCWrite),
      .IorD       (IorD),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RedDst     (RedDst),
      .ALUSrc_A   (ALUSrc_A),
      .ALUSrc_B   (ALUSrc_B),
      .ALU_Control(ALU_Control),
      .DatatoReg  (DatatoReg),
      .RegWrite   (RegWrite),
      .Branch     (Branch),
      .Jal        (Jal),
      .illegal    (illegal),
      .ovf_exc    (ovf_exc),
      .state      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [3:0] observe(input field_e f);
      case (f)
         F_STATE:  return state;
         F_PCW:    return {3'b0, PCWrite};
         F_IORD:   return {3'b0, IorD};
         F_MRD:    return {3'b0, MemRead};
         F_MWR:    return {3'b0, MemWrite};
         F_IRW:    return {3'b0, IRWrite};
         F_REGDST: return {3'b0, RedDst};
         F_SRCA:   return {3'b0, ALUSrc_A};
         F_SRCB:   return {2'b0, ALUSrc_B};
         F_ALU:    return {1'b0, ALU_Control};
         F_D2R:    return {2'b0, DatatoReg};
         F_RW:     return {3'b0, RegWrite};
         F_BR:     return {2'b0, Branch};
         F_JAL:    return {3'b0, Jal};
         F_ILL:    return {3'b0, illegal};
         F_OVF:    return {3'b0, ovf_exc};
         default:  return 4'hx;
      endcase
   endfunction

   task automatic push(input field_e f, input logic [3:0] v, input string tag);
      sb_t e;
      e.f = f;
      e.v = v;
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic ins(input logic [5:0] op, input logic [5:0] fn);
      opcode = op;
      funct  = fn;
   endtask

   // Drive this cycle's handshake/flag inputs, check every queued expectation, then advance.
   task automatic cyc(input logic mr, input logic ovf);
      sb_t        e;
      logic [3:0] obs;
      mem_ready = mr;
      overflow  = ovf;
      #1;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.f);
         n_total++;
         assert (obs === e.v) n_pass++;
         else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; zero = 1'b0; overflow = 1'b0; mem_ready = 1'b0;
      ins(6'h00, 6'h00);
      cyc(1'b0, 1'b0);
      rst = 1'b0;

      // reset state, fetch stalled
      push(F_STATE, 4'd0, "rst.state");   push(F_MRD, 4'd1, "rst.memread");
      push(F_SRCB, 4'd1, "rst.srcb");     push(F_ALU, 4'd2, "rst.alu");
      push(F_RW, 4'd0, "rst.regwrite");   push(F_IRW, 4'd0, "rst.irwrite");
      push(F_PCW, 4'd0, "rst.pcwrite");   push(F_MWR, 4'd0, "rst.memwrite");
      push(F_ILL, 4'd0, "rst.illegal");   push(F_OVF, 4'd0, "rst.ovf_exc");
      cyc(1'b0, 1'b0);

      // add
      ins(6'h00, 6'h20);
      push(F_STATE, 4'd0, "add.if.state"); push(F_IRW, 4'd1, "add.if.irwrite");
      push(F_PCW, 4'd1, "add.if.pcwrite"); push(F_SRCA, 4'd0, "add.if.srca");
      push(F_SRCB, 4'd1, "add.if.srcb");   push(F_ALU, 4'd2, "add.if.alu");
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd1, "add.id.state"); push(F_SRCB, 4'd3, "add.id.srcb");
      push(F_ALU, 4'd2, "add.id.alu");     push(F_ILL, 4'd0, "add.id.illegal");
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd6, "add.ex.state"); push(F_SRCA, 4'd1, "add.ex.srca");
      push(F_SRCB, 4'd0, "add.ex.srcb");   push(F_ALU, 4'd2, "add.ex.alu");
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd7, "add.wb.state"); push(F_REGDST, 4'd1, "add.wb.regdst");
      push(F_RW, 4'd1, "add.wb.regwrite"); push(F_D2R, 4'd0, "add.wb.d2r");
      push(F_OVF, 4'd0, "add.wb.ovf_exc");
      cyc(1'b1, 1'b0);

      // sub with overflow: write suppressed
      ins(6'h00, 6'h22);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd6, "sub.ex.state"); push(F_ALU, 4'd6, "sub.ex.alu");
      cyc(1'b1, 1'b1);
      push(F_STATE, 4'd7, "sub.wb.state"); push(F_RW, 4'd0, "sub.wb.regwrite");
      push(F_OVF, 4'd1, "sub.wb.ovf_exc");
      cyc(1'b1, 1'b0);

      // and with overflow high: no trap
      ins(6'h00, 6'h24);
      push(F_STATE, 4'd0, "and.if.state"); push(F_OVF, 4'd0, "and.if.ovf_exc");
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      push(F_ALU, 4'd0, "and.ex.alu");
      cyc(1'b1, 1'b1);
      push(F_STATE, 4'd7, "and.wb.state"); push(F_RW, 4'd1, "and.wb.regwrite");
      push(F_OVF, 4'd0, "and.wb.ovf_exc");
      cyc(1'b1, 1'b0);

      // lw with one fetch stall and two MEMRD stalls
      ins(6'h23, 6'h00);
      push(F_STATE, 4'd0, "lw.if0.state"); push(F_IRW, 4'd0, "lw.if0.irwrite");
      push(F_MRD, 4'd1, "lw.if0.memread"); push(F_IORD, 4'd0, "lw.if0.iord");
      cyc(1'b0, 1'b0);
      push(F_STATE, 4'd0, "lw.if1.state"); push(F_IRW, 4'd1, "lw.if1.irwrite");
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd1, "lw.id.state");
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd2, "lw.adr.state"); push(F_SRCA, 4'd1, "lw.adr.srca");
      push(F_SRCB, 4'd2, "lw.adr.srcb");   push(F_ALU, 4'd2, "lw.adr.alu");
      push(F_MRD, 4'd0, "lw.adr.memread");
      cyc(1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         push(F_STATE, 4'd3, "lw.rdstall.state"); push(F_IORD, 4'd1, "lw.rdstall.iord");
         push(F_MRD, 4'd1, "lw.rdstall.memread");
         cyc(1'b0, 1'b0);
      end
      push(F_STATE, 4'd3, "lw.rd.state"); push(F_IORD, 4'd1, "lw.rd.iord");
      push(F_MRD, 4'd1, "lw.rd.memread");
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd4, "lw.wb.state"); push(F_D2R, 4'd1, "lw.wb.d2r");
      push(F_REGDST, 4'd0, "lw.wb.regdst"); push(F_RW, 4'd1, "lw.wb.regwrite");
      cyc(1'b1, 1'b0);

      // sw
      ins(6'h2B, 6'h00);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd2, "sw.adr.state");
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd5, "sw.wr.state"); push(F_MWR, 4'd1, "sw.wr.memwrite");
      push(F_IORD, 4'd1, "sw.wr.iord");   push(F_MRD, 4'd0, "sw.wr.memread");
      cyc(1'b1, 1'b0);

      // addi with overflow: suppressed write, then normal fetch
      ins(6'h08, 6'h00);
      push(F_STATE, 4'd0, "addi.if.state");
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd10, "addi.ex.state"); push(F_SRCA, 4'd1, "addi.ex.srca");
      push(F_SRCB, 4'd2, "addi.ex.srcb");    push(F_ALU, 4'd2, "addi.ex.alu");
      cyc(1'b1, 1'b1);
      push(F_STATE, 4'd11, "addi.wb.state"); push(F_RW, 4'd0, "addi.wb.regwrite");
      push(F_OVF, 4'd1, "addi.wb.ovf_exc");  push(F_REGDST, 4'd0, "addi.wb.regdst");
      cyc(1'b1, 1'b0);

      // ori after the trap: fetch is normal, overflow ignored
      ins(6'h0D, 6'h00);
      push(F_STATE, 4'd0, "ori.if.state"); push(F_OVF, 4'd0, "ori.if.ovf_exc");
      push(F_IRW, 4'd1, "ori.if.irwrite");
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd10, "ori.ex.state"); push(F_ALU, 4'd1, "ori.ex.alu");
      cyc(1'b1, 1'b1);
      push(F_STATE, 4'd11, "ori.wb.state"); push(F_RW, 4'd1, "ori.wb.regwrite");
      push(F_OVF, 4'd0, "ori.wb.ovf_exc");
      cyc(1'b1, 1'b0);

      // beq / bne
      ins(6'h04, 6'h00);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd8, "beq.ex.state"); push(F_BR, 4'd1, "beq.ex.branch");
      push(F_ALU, 4'd6, "beq.ex.alu");     push(F_SRCA, 4'd1, "beq.ex.srca");
      push(F_SRCB, 4'd0, "beq.ex.srcb");   push(F_RW, 4'd0, "beq.ex.regwrite");
      cyc(1'b1, 1'b0);
      ins(6'h05, 6'h00);
      push(F_STATE, 4'd0, "bne.if.state");
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd8, "bne.ex.state"); push(F_BR, 4'd2, "bne.ex.branch");
      cyc(1'b1, 1'b0);

      // jal then j
      ins(6'h03, 6'h00);
      push(F_STATE, 4'd0, "jal.if.state");
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd1, "jal.id.state");
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd9, "jal.ex.state"); push(F_BR, 4'd3, "jal.ex.branch");
      push(F_JAL, 4'd1, "jal.ex.jal");     push(F_D2R, 4'd2, "jal.ex.d2r");
      push(F_RW, 4'd1, "jal.ex.regwrite");
      cyc(1'b1, 1'b0);
      ins(6'h02, 6'h00);
      push(F_STATE, 4'd0, "j.if.state"); push(F_JAL, 4'd0, "j.if.jal");
      push(F_BR, 4'd0, "j.if.branch");   push(F_RW, 4'd0, "j.if.regwrite");
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd9, "j.ex.state"); push(F_BR, 4'd3, "j.ex.branch");
      push(F_JAL, 4'd0, "j.ex.jal");     push(F_RW, 4'd0, "j.ex.regwrite");
      cyc(1'b1, 1'b0);

      // illegal opcode, then illegal R-type funct
      ins(6'h3F, 6'h00);
      push(F_STATE, 4'd0, "illop.if.state"); push(F_ILL, 4'd0, "illop.if.illegal");
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd1, "illop.id.state"); push(F_ILL, 4'd1, "illop.id.illegal");
      cyc(1'b1, 1'b0);
      ins(6'h00, 6'h3F);
      push(F_STATE, 4'd0, "illop.next.state"); push(F_ILL, 4'd0, "illop.next.illegal");
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd1, "illfn.id.state"); push(F_ILL, 4'd1, "illfn.id.illegal");
      cyc(1'b1, 1'b0);

      // sw interrupted by reset while stalled in MEMWR
      ins(6'h2B, 6'h00);
      push(F_STATE, 4'd0, "illfn.next.state"); push(F_ILL, 4'd0, "illfn.next.illegal");
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      push(F_STATE, 4'd5, "swrst.stall.state"); push(F_MWR, 4'd1, "swrst.stall.memwrite");
      cyc(1'b0, 1'b0);
      rst = 1'b1;
      push(F_STATE, 4'd5, "swrst.rst.state"); push(F_IORD, 4'd1, "swrst.rst.iord");
      cyc(1'b0, 1'b0);
      rst = 1'b0;
      push(F_STATE, 4'd0, "swrst.after.state");   push(F_MWR, 4'd0, "swrst.after.memwrite");
      push(F_MRD, 4'd1, "swrst.after.memread");   push(F_RW, 4'd0, "swrst.after.regwrite");
      push(F_IORD, 4'd0, "swrst.after.iord");
      cyc(1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
